// File: rtl/lpif_x2_link_online_ctrl.sv
// Link bring-up sequencer for the x2 asym1 half-rate LPIF slave datapath.
// Brings tx_online up after a programmable delay once the AIB channel is
// ready, qualifies rx lock by counting strobe userbits from rx_phy0, and
// tears the link down with a sticky error when strobes stop after lock.
module lpif_x2_link_online_ctrl #(
    parameter int DLY_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr_n,
    input  logic                 link_enable,
    input  logic                 phy_ready,
    input  logic                 rx_stb_bit,
    input  logic [DLY_WIDTH-1:0] delay_tx_value,
    input  logic [CNT_WIDTH-1:0] stb_lock_count,
    input  logic [CNT_WIDTH-1:0] stb_timeout,
    input  logic                 err_clear,
    output logic                 tx_online,
    output logic                 rx_online,
    output logic [2:0]           ctrl_state,
    output logic [CNT_WIDTH-1:0] lock_cnt,
    output logic                 link_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_DLY  = 3'd1,
        ST_RX_LOCK = 3'd2,
        ST_RX_ON   = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [DLY_WIDTH-1:0] dly_cnt, dly_nxt;
    logic [CNT_WIDTH-1:0] lock_q, lock_nxt;
    logic [CNT_WIDTH-1:0] gap_q, gap_nxt;
    logic [CNT_WIDTH-1:0] lock_inc, gap_inc, lock_target;
    logic                 gap_hit;
    logic                 err_set;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == '1)
            return v;
        return v + CNT_WIDTH'(1);
    endfunction

    assign lock_inc    = sat_inc(lock_q);
    assign gap_inc     = sat_inc(gap_q);
    // A lock threshold of zero behaves like one strobe.
    assign lock_target = (stb_lock_count == '0) ? CNT_WIDTH'(1) : stb_lock_count;
    // Strobe loss only when this cycle carries no strobe; a strobe on the
    // expiry cycle keeps the link alive.
    assign gap_hit     = !rx_stb_bit && (stb_timeout != '0) && (gap_inc >= stb_timeout);

    assign ctrl_state = state;
    assign lock_cnt   = lock_q;

    // Next-state and counter update; abort overrides everything except ERROR.
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        lock_nxt  = lock_q;
        gap_nxt   = gap_q;
        err_set   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (link_enable && phy_ready) begin
                    state_nxt = ST_TX_DLY;
                    dly_nxt   = delay_tx_value;
                end
            end
            ST_TX_DLY: begin
                if (dly_cnt == '0)
                    state_nxt = ST_RX_LOCK;
                else
                    dly_nxt = dly_cnt - DLY_WIDTH'(1);
            end
            ST_RX_LOCK: begin
                if (rx_stb_bit) begin
                    lock_nxt = lock_inc;
                    gap_nxt  = '0;
                    if (lock_inc >= lock_target)
                        state_nxt = ST_RX_ON;
                end else if (gap_hit) begin
                    lock_nxt = '0;
                    gap_nxt  = '0;
                end else begin
                    gap_nxt = gap_inc;
                end
            end
            ST_RX_ON: begin
                if (rx_stb_bit) begin
                    gap_nxt = '0;
                end else if (gap_hit) begin
                    state_nxt = ST_ERROR;
                    gap_nxt   = '0;
                    err_set   = 1'b1;
                end else begin
                    gap_nxt = gap_inc;
                end
            end
            ST_ERROR: begin
                if (!link_enable) begin
                    state_nxt = ST_IDLE;
                    dly_nxt   = '0;
                    lock_nxt  = '0;
                    gap_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                dly_nxt   = '0;
                lock_nxt  = '0;
                gap_nxt   = '0;
            end
        endcase

        if ((state != ST_ERROR) && (!link_enable || !phy_ready)) begin
            state_nxt = ST_IDLE;
            dly_nxt   = '0;
            lock_nxt  = '0;
            gap_nxt   = '0;
            err_set   = 1'b0;
        end
    end

    // State, counters, registered online decodes and sticky error flag.
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            state     <= ST_IDLE;
            dly_cnt   <= '0;
            lock_q    <= '0;
            gap_q     <= '0;
            tx_online <= 1'b0;
            rx_online <= 1'b0;
            link_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            dly_cnt   <= dly_nxt;
            lock_q    <= lock_nxt;
            gap_q     <= gap_nxt;
            tx_online <= (state == ST_RX_LOCK) || (state == ST_RX_ON);
            rx_online <= (state == ST_RX_ON);
            if (err_set)
                link_err <= 1'b1;
            else if (err_clear)
                link_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lpif_x2_link_online_ctrl.sv
// Self-checking bench for lpif_x2_link_online_ctrl. Each scenario task pushes
// the expected output snapshot for an edge into a scoreboard queue as it
// drives that edge's stimulus, then pops and compares once the edge is past.
module tb_lpif_x2_link_online_ctrl;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk_wr = 1'b0;
    logic          rst_wr_n;
    logic          link_enable;
    logic          phy_ready;
    logic          rx_stb_bit;
    logic [DW-1:0] delay_tx_value;
    logic [CW-1:0] stb_lock_count;
    logic [CW-1:0] stb_timeout;
    logic          err_clear;
    logic          tx_online;
    logic          rx_online;
    logic [2:0]    ctrl_state;
    logic [CW-1:0] lock_cnt;
    logic          link_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string         tag;
        int            edge_n;
        logic [2:0]    st;
        logic          tx;
        logic          rx;
        logic          err;
        logic [CW-1:0] lock;
    } exp_t;

    exp_t sbq[$];

    always #5 clk_wr = ~clk_wr;

    lpif_x2_link_online_ctrl #(.DLY_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_wr         (clk_wr),
        .rst_wr_n       (rst_wr_n),
        .link_enable    (link_enable),
        .phy_ready      (phy_ready),
        .rx_stb_bit     (rx_stb_bit),
        .delay_tx_value (delay_tx_value),
        .stb_lock_count (stb_lock_count),
        .stb_timeout    (stb_timeout),
        .err_clear      (err_clear),
        .tx_online      (tx_online),
        .rx_online      (rx_online),
        .ctrl_state     (ctrl_state),
        .lock_cnt       (lock_cnt),
        .link_err       (link_err)
    );

    // Advance one rising edge; outputs are then sampled and inputs driven at the falling edge.
    task automatic tick();
        @(posedge clk_wr);
        @(negedge clk_wr);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_wr_n       = 1'b0;
        link_enable    = 1'b1;
        phy_ready      = 1'b1;
        rx_stb_bit     = 1'b1;
        err_clear      = 1'b0;
        delay_tx_value = '0;
        stb_lock_count = '0;
        stb_timeout    = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                rst_wr_n    = 1'b1;
                link_enable = 1'b0;
            end
            sbq.push_back('{"reset", i, 3'd0, 1'b0, 1'b0, 1'b0, CW'(0)});
            tick();
            e = sbq.pop_front();
            checks++;
            if ({ctrl_state, tx_online, rx_online, link_err, lock_cnt} !== {e.st, e.tx, e.rx, e.err, e.lock}) begin
                errors++;
                $display("FAIL %s edge %0d: got st=%0d tx=%0b rx=%0b err=%0b lock=%0d, want st=%0d tx=%0b rx=%0b err=%0b lock=%0d",
                         e.tag, e.edge_n, ctrl_state, tx_online, rx_online, link_err, lock_cnt,
                         e.st, e.tx, e.rx, e.err, e.lock);
            end
        end
    endtask

    // Full bring-up from IDLE with strobes on every cycle, ending one edge after RX_ON.
    task automatic test_bringup(input string tag, input int d, input int l, input int to);
        exp_t e;
        int   t;
        int   st;
        int   lk;
        t = (l == 0) ? 1 : l;
        delay_tx_value = DW'(d);
        stb_lock_count = CW'(l);
        stb_timeout    = CW'(to);
        rx_stb_bit     = 1'b1;
        link_enable    = 1'b1;
        phy_ready      = 1'b1;
        for (int k = 0; k <= d + 2 + t; k++) begin
            if (k <= d)
                st = 1;
            else if (k < d + 1 + t)
                st = 2;
            else
                st = 3;
            if (k <= d + 1)
                lk = 0;
            else if (k - d - 1 < t)
                lk = k - d - 1;
            else
                lk = t;
            sbq.push_back('{tag, k, 3'(st), (k >= d + 2), (k >= d + 2 + t), 1'b0, CW'(lk)});
            tick();
            if (k == 0)
                delay_tx_value = 16'hFFFF;
            e = sbq.pop_front();
            checks++;
            if ({ctrl_state, tx_online, rx_online, link_err, lock_cnt} !== {e.st, e.tx, e.rx, e.err, e.lock}) begin
                errors++;
                $display("FAIL %s edge %0d: got st=%0d tx=%0b rx=%0b err=%0b lock=%0d, want st=%0d tx=%0b rx=%0b err=%0b lock=%0d",
                         e.tag, e.edge_n, ctrl_state, tx_online, rx_online, link_err, lock_cnt,
                         e.st, e.tx, e.rx, e.err, e.lock);
            end
        end
    endtask

    // Lock 8, timeout 5: partial lock is lost after 5 quiet cycles, and a strobe on the expiry cycle wins.
    task automatic test_lock_timeout();
        exp_t e;
        logic stb_tab [18] = '{1,1,1, 0,0,0,0,0, 0,0,0,0, 1, 0,0,0,0, 0};
        int   lk_tab  [18] = '{1,2,3, 3,3,3,3,0, 0,0,0,0, 1, 1,1,1,1, 0};
        delay_tx_value = '0;
        stb_lock_count = 8'd8;
        stb_timeout    = 8'd5;
        rx_stb_bit     = 1'b1;
        link_enable    = 1'b1;
        phy_ready      = 1'b1;
        for (int k = 0; k < 22; k++) begin
            if (k == 0)
                sbq.push_back('{"lock_to", k, 3'd1, 1'b0, 1'b0, 1'b0, CW'(0)});
            else if (k == 1)
                sbq.push_back('{"lock_to", k, 3'd2, 1'b0, 1'b0, 1'b0, CW'(0)});
            else if (k < 20) begin
                rx_stb_bit = stb_tab[k-2];
                sbq.push_back('{"lock_to", k, 3'd2, 1'b1, 1'b0, 1'b0, CW'(lk_tab[k-2])});
            end else begin
                link_enable = 1'b0;
                sbq.push_back('{"lock_to", k, 3'd0, (k == 20), 1'b0, 1'b0, CW'(0)});
            end
            tick();
            e = sbq.pop_front();
            checks++;
            if ({ctrl_state, tx_online, rx_online, link_err, lock_cnt} !== {e.st, e.tx, e.rx, e.err, e.lock}) begin
                errors++;
                $display("FAIL %s edge %0d: got st=%0d tx=%0b rx=%0b err=%0b lock=%0d, want st=%0d tx=%0b rx=%0b err=%0b lock=%0d",
                         e.tag, e.edge_n, ctrl_state, tx_online, rx_online, link_err, lock_cnt,
                         e.st, e.tx, e.rx, e.err, e.lock);
            end
        end
    endtask

    // Strobe loss in RX_ON: ERROR after 5 gaps, set beats a same-cycle clear, phy_ready ignored in ERROR.
    task automatic test_rx_on_loss();
        exp_t e;
        // stimulus {rst_n, stb, clr, en, rdy}; expectation {st, tx, rx, err}
        logic [4:0] stim [10] = '{5'b10011, 5'b10011, 5'b10011, 5'b10011, 5'b10111,
                                  5'b10010, 5'b10010, 5'b10000, 5'b10100, 5'b10001};
        logic [5:0] expv [10] = '{6'b011_110, 6'b011_110, 6'b011_110, 6'b011_110, 6'b100_111,
                                  6'b100_001, 6'b100_001, 6'b000_001, 6'b000_000, 6'b000_000};
        int         lk   [10] = '{2, 2, 2, 2, 2, 2, 2, 0, 0, 0};
        test_bringup("loss_up", 1, 2, 5);
        for (int k = 0; k < 10; k++) begin
            {rst_wr_n, rx_stb_bit, err_clear, link_enable, phy_ready} = stim[k];
            sbq.push_back('{"loss", k, expv[k][5:3], expv[k][2], expv[k][1], expv[k][0], CW'(lk[k])});
            tick();
            e = sbq.pop_front();
            checks++;
            if ({ctrl_state, tx_online, rx_online, link_err, lock_cnt} !== {e.st, e.tx, e.rx, e.err, e.lock}) begin
                errors++;
                $display("FAIL %s edge %0d: got st=%0d tx=%0b rx=%0b err=%0b lock=%0d, want st=%0d tx=%0b rx=%0b err=%0b lock=%0d",
                         e.tag, e.edge_n, ctrl_state, tx_online, rx_online, link_err, lock_cnt,
                         e.st, e.tx, e.rx, e.err, e.lock);
            end
        end
    endtask

    // phy_ready drop in RX_ON aborts to IDLE without an error, then the link comes back up.
    task automatic test_phy_drop();
        exp_t e;
        logic [5:0] expv [3] = '{6'b000_110, 6'b000_000, 6'b000_000};
        test_bringup("drop_up", 2, 3, 0);
        for (int k = 0; k < 3; k++) begin
            phy_ready = 1'b0;
            sbq.push_back('{"drop", k, expv[k][5:3], expv[k][2], expv[k][1], expv[k][0], CW'(0)});
            tick();
            e = sbq.pop_front();
            checks++;
            if ({ctrl_state, tx_online, rx_online, link_err, lock_cnt} !== {e.st, e.tx, e.rx, e.err, e.lock}) begin
                errors++;
                $display("FAIL %s edge %0d: got st=%0d tx=%0b rx=%0b err=%0b lock=%0d, want st=%0d tx=%0b rx=%0b err=%0b lock=%0d",
                         e.tag, e.edge_n, ctrl_state, tx_online, rx_online, link_err, lock_cnt,
                         e.st, e.tx, e.rx, e.err, e.lock);
            end
        end
        test_bringup("drop_reup", 2, 3, 0);
    endtask

    // One-cycle reset in TX_DLY, then a back-to-back resequence with delay 6 and lock 1.
    task automatic test_reset_mid();
        exp_t e;
        logic [4:0] stim [16] = '{5'b11001, 5'b11001, 5'b11011, 5'b11011, 5'b01011,
                                  5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11011,
                                  5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11001};
        logic [5:0] expv [16] = '{6'b000_110, 6'b000_000, 6'b001_000, 6'b001_000, 6'b000_000,
                                  6'b001_000, 6'b001_000, 6'b001_000, 6'b001_000, 6'b001_000,
                                  6'b001_000, 6'b001_000, 6'b010_000, 6'b011_100, 6'b011_110, 6'b000_110};
        int         lk   [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        delay_tx_value = 16'd6;
        stb_lock_count = 8'd1;
        stb_timeout    = 8'd0;
        for (int k = 0; k < 16; k++) begin
            {rst_wr_n, rx_stb_bit, err_clear, link_enable, phy_ready} = stim[k];
            sbq.push_back('{"rst_mid", k, expv[k][5:3], expv[k][2], expv[k][1], expv[k][0], CW'(lk[k])});
            tick();
            e = sbq.pop_front();
            checks++;
            if ({ctrl_state, tx_online, rx_online, link_err, lock_cnt} !== {e.st, e.tx, e.rx, e.err, e.lock}) begin
                errors++;
                $display("FAIL %s edge %0d: got st=%0d tx=%0b rx=%0b err=%0b lock=%0d, want st=%0d tx=%0b rx=%0b err=%0b lock=%0d",
                         e.tag, e.edge_n, ctrl_state, tx_online, rx_online, link_err, lock_cnt,
                         e.st, e.tx, e.rx, e.err, e.lock);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup("bringup_d3_l4", 3, 4, 0);
        link_enable = 1'b0;
        tick();
        tick();
        test_bringup("bringup_d0_l0", 0, 0, 0);
        link_enable = 1'b0;
        tick();
        tick();
        test_lock_timeout();
        test_rx_on_loss();
        test_phy_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
